neg_serial_unit: RTL and testbench

//   Parametrised, bit-serial two's-complement sign unit; sequential successor to the combinational 8-bit conditional negator.

---
 rtl/neg_serial_unit.sv | 132 +++++++++++++
 tb/tb_neg_serial_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neg_serial_unit.sv
// Bit-serial two's-complement sign unit: pass, negate, abs or -abs.
// Processes one operand bit per clock, LSB first, using the first-one rule.
module neg_serial_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic               inv_q, inv_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_zero_q, out_zero_d;

  logic               bit_r;
  logic [WIDTH-1:0]   res_shift;
  logic               cap_inv;

  always_comb begin
    bit_r     = inv_q ? (sreg_q[0] ^ seen_q) : sreg_q[0];
    res_shift = {bit_r, res_q[WIDTH-1:1]};
    cap_inv   = (in_mode == 2'b01) |
                ((in_mode == 2'b10) & in_data[WIDTH-1]) |
                ((in_mode == 2'b11) & ~in_data[WIDTH-1]);
  end

  // clr overrides everything, so the case body only runs when it is low
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    inv_d      = inv_q;
    ovf_pend_d = ovf_pend_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_zero_d = out_zero_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d    = SHIFT;
            sreg_d     = in_data;
            res_d      = '0;
            cnt_d      = '0;
            seen_d     = 1'b0;
            inv_d      = cap_inv;
            ovf_pend_d = cap_inv & (in_data == MIN_VAL);
          end
        end
        SHIFT: begin
          sreg_d = sreg_q >> 1;
          seen_d = seen_q | sreg_q[0];
          res_d  = res_shift;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d    = DONE;
            out_data_d = res_shift;
            out_ovf_d  = ovf_pend_q;
            out_zero_d = (res_shift == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      inv_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      inv_q      <= inv_d;
      ovf_pend_q <= ovf_pend_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_neg_serial_unit.sv
// Directed bench for neg_serial_unit: an 8-bit instance for single operations
// and a 16-bit instance for a back-to-back stream.
module tb_neg_serial_unit;

  logic        clk;
  logic        rst_n;

  logic        clr8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [1:0]  in_mode8;
  logic        out_ovf8, out_zero8, busy8;

  logic        clr16, in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_data16, out_data16;
  logic [1:0]  in_mode16;
  logic        out_ovf16, out_zero16, busy16;

  int checks = 0;
  int errors = 0;

  neg_serial_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_ovf(out_ovf8), .out_zero(out_zero8), .busy(busy8)
  );

  neg_serial_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr16),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_mode(in_mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
    .out_ovf(out_ovf16), .out_zero(out_zero16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start8(input logic [7:0] data, input logic [1:0] mode);
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = data;
    in_mode8  = mode;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_done8(output logic [7:0] d, output logic o, output logic z, output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = out_data8;
    o = out_ovf8;
    z = out_zero8;
  endtask

  task automatic consume8();
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || out_data8 !== 8'h00 ||
        out_ovf8 !== 1'b0 || out_zero8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: rdy=%b vld=%b data=%h ovf=%b zero=%b busy=%b expected 1 0 00 0 0 0",
               in_ready8, out_valid8, out_data8, out_ovf8, out_zero8, busy8);
    end
    checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || out_data16 !== 16'h0000 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: rdy=%b vld=%b data=%h busy=%b expected 1 0 0000 0",
               in_ready16, out_valid16, out_data16, busy16);
    end
  endtask

  task automatic test_negate();
    logic [7:0] d;
    logic       o, z;
    int         lat;
    start8(8'h05, 2'b01);
    wait_done8(d, o, z, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL neg_latency: got %0d expected 8", lat);
    end
    checks++;
    if (d !== 8'hFB || o !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL neg_05: data=%h ovf=%b zero=%b expected FB 0 0", d, o, z);
    end
    checks++;
    if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL done_flags: in_ready=%b busy=%b expected 0 1", in_ready8, busy8);
    end
    consume8();
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || out_data8 !== 8'hFB) begin
      errors++;
      $display("FAIL consume: in_ready=%b out_valid=%b data=%h expected 1 0 FB",
               in_ready8, out_valid8, out_data8);
    end
  endtask

  task automatic test_modes();
    logic [7:0] vin  [10] = '{8'h80, 8'h80, 8'h80, 8'hF4, 8'h0C, 8'h00, 8'h37, 8'h00, 8'h80, 8'h7F};
    logic [1:0] vmod [10] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
    logic [7:0] vexp [10] = '{8'h80, 8'h80, 8'h80, 8'h0C, 8'hF4, 8'h00, 8'h37, 8'h00, 8'h80, 8'h7F};
    logic       vovf [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       vzer [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] d;
    logic       o, z;
    int         lat;
    for (int i = 0; i < 10; i++) begin
      start8(vin[i], vmod[i]);
      wait_done8(d, o, z, lat);
      checks++;
      if (d !== vexp[i] || o !== vovf[i] || z !== vzer[i]) begin
        errors++;
        $display("FAIL mode_vec%0d in=%h mode=%b: data=%h ovf=%b zero=%b expected %h %b %b",
                 i, vin[i], vmod[i], d, o, z, vexp[i], vovf[i], vzer[i]);
      end
      consume8();
    end
  endtask

  task automatic test_stall();
    logic [7:0] d;
    logic       o, z;
    int         lat;
    int         bad;
    start8(8'h05, 2'b01);
    wait_done8(d, o, z, lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data8 !== 8'hFB || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles, last data=%h vld=%b rdy=%b expected FB 1 0",
               bad, out_data8, out_valid8, in_ready8);
    end
    consume8();
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b expected 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic       o, z;
    int         lat;
    int         seen_valid;
    // clr during SHIFT cycle 3; out_data keeps the previous FB result
    start8(8'h33, 2'b01);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr8 = 1'b1;
    @(posedge clk);
    #1;
    clr8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b1 || out_data8 !== 8'hFB) begin
      errors++;
      $display("FAIL clr_shift: busy=%b rdy=%b data=%h expected 0 1 FB", busy8, in_ready8, out_data8);
    end
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid8 === 1'b1) seen_valid++;
    end
    checks++;
    if (seen_valid !== 0) begin
      errors++;
      $display("FAIL clr_no_valid: out_valid seen %0d cycles expected 0", seen_valid);
    end
    // clr on the same edge as an accept wins
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = 8'h11;
    in_mode8  = 2'b01;
    clr8      = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    clr8      = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL clr_accept: busy=%b rdy=%b expected 0 1", busy8, in_ready8);
    end
    // async reset during SHIFT cycle 5
    start8(8'h44, 2'b01);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || in_ready8 !== 1'b1 || out_data8 !== 8'h00 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_shift: busy=%b rdy=%b data=%h vld=%b expected 0 1 00 0",
               busy8, in_ready8, out_data8, out_valid8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid8 === 1'b1) seen_valid++;
    end
    checks++;
    if (seen_valid !== 0) begin
      errors++;
      $display("FAIL rst_no_valid: out_valid seen %0d cycles expected 0", seen_valid);
    end
    start8(8'h01, 2'b01);
    wait_done8(d, o, z, lat);
    checks++;
    if (d !== 8'hFF || o !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: data=%h ovf=%b zero=%b expected FF 0 0", d, o, z);
    end
    consume8();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vin  [7] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0001, 16'hABCD, 16'h0000, 16'h8000};
    logic [1:0]  vmod [7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [15:0] vexp [7] = '{16'hEDCC, 16'h8000, 16'h0001, 16'hFFFF, 16'hABCD, 16'h0000, 16'h8000};
    logic        vovf [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          issued = 0;
    int          got = 0;
    int          last_cycle = 0;
    out_ready16 = 1'b1;
    for (int c = 0; c < 400 && got < 7; c++) begin
      @(negedge clk);
      if (out_valid16 === 1'b1) begin
        checks++;
        if (out_data16 !== vexp[got] || out_ovf16 !== vovf[got] || out_zero16 !== (vexp[got] == 16'h0)) begin
          errors++;
          $display("FAIL b2b_res%0d: data=%h ovf=%b zero=%b expected %h %b %b", got,
                   out_data16, out_ovf16, out_zero16, vexp[got], vovf[got], (vexp[got] == 16'h0));
        end
        if (got > 0) begin
          checks++;
          if (c - last_cycle !== 18) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d edges expected 18", got, c - last_cycle);
          end
        end
        last_cycle = c;
        got++;
      end
      if (in_ready16 === 1'b1) begin
        if (issued < 7) begin
          in_valid16 = 1'b1;
          in_data16  = vin[issued];
          in_mode16  = vmod[issued];
          issued++;
        end else begin
          in_valid16 = 1'b0;
        end
      end
    end
    in_valid16 = 1'b0;
    checks++;
    if (got !== 7) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 7", got);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    clr8        = 1'b0;
    in_valid8   = 1'b0;
    in_data8    = 8'h00;
    in_mode8    = 2'b00;
    out_ready8  = 1'b0;
    clr16       = 1'b0;
    in_valid16  = 1'b0;
    in_data16   = 16'h0000;
    in_mode16   = 2'b00;
    out_ready16 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_negate();
    test_modes();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
